// File: rtl/cam_pkg.sv
// Shared types and defaults for the camera capture sequencer.
package cam_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned WORD_W       = 16;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SYNC,
    CAPTURE,
    DONE
  } cam_state_e;

  // RGB565 word as it leaves the packer: first camera byte in the upper half.
  typedef struct packed {
    logic [BYTE_W-1:0] hi;
    logic [BYTE_W-1:0] lo;
  } rgb565_word_t;

endpackage

// File: rtl/cam_sync_edge.sv
// Camera input register stage with vsync rise/fall and href fall strobes
// derived from the registered copies against a second delay stage.
module cam_sync_edge
  import cam_pkg::*;
(
  input  logic              pclk,
  input  logic              reset,
  input  logic              vsync_i,
  input  logic              href_i,
  input  logic [BYTE_W-1:0] din_i,
  output logic              hr_o,
  output logic [BYTE_W-1:0] d_o,
  output logic              vs_rise_c,
  output logic              vs_fall_c,
  output logic              hr_fall_c
);

  logic              vs_q;
  logic              vs_qq;
  logic              hr_q;
  logic              hr_qq;
  logic [BYTE_W-1:0] d_q;

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      vs_q  <= 1'b0;
      vs_qq <= 1'b0;
      hr_q  <= 1'b0;
      hr_qq <= 1'b0;
      d_q   <= '0;
    end else begin
      vs_q  <= vsync_i;
      vs_qq <= vs_q;
      hr_q  <= href_i;
      hr_qq <= hr_q;
      d_q   <= din_i;
    end
  end

  assign hr_o      = hr_q;
  assign d_o       = d_q;
  assign vs_rise_c = vs_q & ~vs_qq;
  assign vs_fall_c = ~vs_q & vs_qq;
  assign hr_fall_c = ~hr_q & hr_qq;

endmodule

// File: rtl/cam_capture_ctrl.sv
// Frame-capture sequencer: arms on start, aligns to vsync, packs byte pairs
// into RGB565 FIFO writes. Optional crop window enabled by CAM_CROP_EN.
module cam_capture_ctrl
  import cam_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned XW       = 10,
  parameter int unsigned YW       = 9
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              vsync,
  input  logic              href,
  input  logic [BYTE_W-1:0] din,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  input  logic              fifo_full,
`ifdef CAM_CROP_EN
  input  logic [XW-1:0]     crop_x0,
  input  logic [XW-1:0]     crop_x1,
  input  logic [YW-1:0]     crop_y0,
  input  logic [YW-1:0]     crop_y1,
`endif
  output logic              fifo_wr,
  output logic [WORD_W-1:0] fifo_data,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow,
  output logic [YW-1:0]     line_cnt,
  output logic [XW-1:0]     word_cnt,
  output logic [7:0]        frame_cnt
);

  logic              hr_q;
  logic [BYTE_W-1:0] d_q;
  logic              vs_rise_c;
  logic              vs_fall_c;
  logic              hr_fall_c;

  cam_sync_edge u_sync (
    .pclk      (pclk),
    .reset     (reset),
    .vsync_i   (vsync),
    .href_i    (href),
    .din_i     (din),
    .hr_o      (hr_q),
    .d_o       (d_q),
    .vs_rise_c (vs_rise_c),
    .vs_fall_c (vs_fall_c),
    .hr_fall_c (hr_fall_c)
  );

  cam_state_e        state_q, state_d;
  logic              phase_q, phase_d;
  logic [BYTE_W-1:0] hi_q, hi_d;
  logic              fifo_wr_q, fifo_wr_d;
  rgb565_word_t      fifo_data_q, fifo_data_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              overflow_q, overflow_d;
  logic [YW-1:0]     line_q, line_d;
  logic [XW-1:0]     word_q, word_d;
  logic [7:0]        frame_q, frame_d;

  logic              in_win_c;
  logic              word_sat_c;
  logic              line_sat_c;

  // Write window: active-area limits, narrowed by the crop rectangle when built in.
  always_comb begin
    in_win_c = (word_q < XW'(H_ACTIVE)) && (line_q < YW'(V_ACTIVE));
`ifdef CAM_CROP_EN
    in_win_c = in_win_c && (word_q >= crop_x0) && (word_q < crop_x1)
                        && (line_q >= crop_y0) && (line_q < crop_y1);
`endif
  end

  assign word_sat_c = (word_q >= XW'(H_ACTIVE));
  assign line_sat_c = (line_q >= YW'(V_ACTIVE));

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    hi_d         = hi_q;
    fifo_wr_d    = 1'b0;
    fifo_data_d  = fifo_data_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
    line_d       = line_q;
    word_d       = word_q;
    frame_d      = frame_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = ARM;
          overflow_d = 1'b0;
          line_d     = '0;
          word_d     = '0;
        end
      end
      ARM: begin
        if (vs_rise_c) state_d = SYNC;
      end
      SYNC: begin
        if (vs_fall_c) begin
          state_d = CAPTURE;
          phase_d = 1'b0;
          line_d  = '0;
          word_d  = '0;
        end
      end
      CAPTURE: begin
        if (hr_q) begin
          if (!phase_q) begin
            hi_d    = d_q;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (in_win_c) begin
              if (fifo_full) begin
                overflow_d = 1'b1;
              end else begin
                fifo_wr_d      = 1'b1;
                fifo_data_d.hi = hi_q;
                fifo_data_d.lo = d_q;
              end
            end
            if (!word_sat_c) word_d = word_q + XW'(1);
          end
        end else if (hr_fall_c) begin
          // End of line: an unpaired trailing byte is simply forgotten.
          if (!line_sat_c) line_d = line_q + YW'(1);
          word_d  = '0;
          phase_d = 1'b0;
        end
        if (vs_rise_c) begin
          state_d      = DONE;
          frame_done_d = 1'b1;
          frame_d      = frame_q + 8'd1;
        end
      end
      DONE: begin
        state_d = continuous ? SYNC : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything, including a start in the same cycle.
    if (stop) begin
      state_d      = IDLE;
      phase_d      = 1'b0;
      fifo_wr_d    = 1'b0;
      frame_done_d = 1'b0;
      frame_d      = frame_q;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      phase_q      <= 1'b0;
      hi_q         <= '0;
      fifo_wr_q    <= 1'b0;
      fifo_data_q  <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      line_q       <= '0;
      word_q       <= '0;
      frame_q      <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      hi_q         <= hi_d;
      fifo_wr_q    <= fifo_wr_d;
      fifo_data_q  <= fifo_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      line_q       <= line_d;
      word_q       <= word_d;
      frame_q      <= frame_d;
    end
  end

  assign fifo_wr    = fifo_wr_q;
  assign fifo_data  = fifo_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign line_cnt   = line_q;
  assign word_cnt   = word_q;
  assign frame_cnt  = frame_q;

endmodule

// File: doc/cam_capture_ctrl.md
# cam_capture_ctrl

Frame-capture sequencer between the camera pixel port and the camera FIFO in the Wishbone camera subsystem. Arms on a software start, aligns to a clean frame boundary using vsync/href, packs byte pairs into 16-bit RGB565 words and issues FIFO write strobes. Reports line/word position, frame completion and overflow to the Wishbone register block.

## Interface
Parameters:
- H_ACTIVE, 640, max words written per line
- V_ACTIVE, 480, max lines written per frame
- XW, 10, width of word counter (must hold H_ACTIVE)
- YW, 9, width of line counter (must hold V_ACTIVE)

Ports:
- pclk  in  1  single clock (camera pixel clock)
- reset  in  1  asynchronous, active-low reset
- vsync  in  1  camera vsync, high = vertical blanking
- href  in  1  camera href, high = valid byte on din
- din  in  8  camera data byte
- start  in  1  one-cycle pulse, arm capture; ignored when busy=1
- stop  in  1  one-cycle pulse, abort to IDLE
- continuous  in  1  1 = re-arm after each frame; sampled in DONE
- fifo_full  in  1  FIFO full flag
- fifo_wr  out  1  one-cycle write strobe
- fifo_data  out  16  packed word {first byte, second byte}
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse at end of captured frame
- overflow  out  1  sticky, word dropped because fifo_full=1; cleared by start
- line_cnt  out  YW  lines completed in current frame
- word_cnt  out  XW  words written in current line
- frame_cnt  out  8  frames completed since reset, wraps 255->0

## Operation
- Input stage: vsync, href, din registered once (vs_q, hr_q, d_q); edges from vs_q/hr_q versus a second delay stage.
- States: IDLE, ARM, SYNC, CAPTURE, DONE.
- IDLE: start -> ARM, clear overflow, line_cnt, word_cnt.
- ARM: wait vsync rising edge -> SYNC (start mid-frame never captures a partial frame).
- SYNC: wait vsync falling edge -> CAPTURE, phase=0, counters 0.
- CAPTURE, hr_q=1: phase 0 latches d_q as high byte, phase toggles; phase 1 forms word. Word is written iff word_cnt<H_ACTIVE, line_cnt<V_ACTIVE and fifo_full=0; then word_cnt+1. If in window but fifo_full=1: word dropped, overflow=1, word_cnt still +1.
- href falling edge: line_cnt+1 (saturating at V_ACTIVE), word_cnt=0, phase=0; odd trailing byte discarded.
- vsync rising edge in CAPTURE -> DONE.
- DONE (one cycle): frame_done=1, frame_cnt+1; continuous=1 -> SYNC, else IDLE.
- stop in any state -> IDLE next cycle; pending half-word discarded; no frame_done. stop and start in same cycle: stop wins.
- Counters never wrap inside a frame; frame_cnt wraps modulo 256.

## Timing
- Reset values: fifo_wr=0, fifo_data=0, busy=0, frame_done=0, overflow=0, line_cnt=0, word_cnt=0, frame_cnt=0, state IDLE, phase=0.
- Latency: second byte on din at edge n -> fifo_wr=1 with fifo_data valid in cycle after edge n+1.
- fifo_wr never high two consecutive cycles (one word per two bytes).
- fifo_full sampled in the cycle the word is formed; no retry, no backpressure to camera.
- busy rises cycle after start; falls cycle after DONE (non-continuous) or after stop.
- frame_done coincident with DONE state; frame_cnt updates same edge.

## Configuration
- CAM_CROP_EN defined: adds inputs crop_x0, crop_x1 (XW) and crop_y0, crop_y1 (YW), static during capture; word written only if crop_x0<=word_cnt<crop_x1 and crop_y0<=line_cnt<crop_y1 (plus H/V limits). Counters still count every word/line.
- Undefined: crop ports absent; window is full H_ACTIVE x V_ACTIVE.

## Structure
- Package cam_pkg: state enum (IDLE, ARM, SYNC, CAPTURE, DONE), default H_ACTIVE/V_ACTIVE constants, word width 16.
- Sub-module cam_sync_edge: input register stage plus rise/fall strobes for vsync and href; FSM, packing and counters stay in cam_capture_ctrl.

## Test plan
- Reset, start, 4-line frame of 8 bytes/line (0x01..0x08) -> 16 fifo_wr, first word 0x0102, line_cnt=4 before DONE, one frame_done, frame_cnt=1.
- start asserted with vsync low mid-frame -> no writes until next vsync high->low; that frame captured whole.
- fifo_full held high for 3 words of line 0 -> those 3 not written, overflow=1, word_cnt reaches 4; next start clears overflow.
- Line of 7 bytes -> 3 words written, 7th byte dropped; next line starts at phase 0 with correct pairing.
- continuous=1 over 3 frames, stop pulsed mid-third -> frame_cnt=2, IDLE next cycle, no third frame_done, busy=0.
- CAM_CROP_EN, crop x 1..3, y 1..2 on 4x4-word frame -> exactly 2 words/line on line 1 only (2 writes).
